// File: rtl/pp_burst_tx.sv
// Burst word generator with pull-based flow control.
// Emits LEN+1 words (increment or LFSR pattern) and keeps a running XOR of what it pushed.
module pp_burst_tx #(
  parameter int BW = 32,
  parameter int LW = 8
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          START,
  input  logic          ABORT,
  input  logic          MODE,
  input  logic [LW-1:0] LEN,
  input  logic [BW-1:0] SEED,
  output logic          BUSY,
  input  logic          DOPULL,
  output logic          DOPUSH,
  output logic [BW-1:0] DOUT,
  output logic          DOLAST,
  output logic [BW-1:0] SUM
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  localparam logic [LW:0] REM_ONE = {{LW{1'b0}}, 1'b1};

  state_t        state_q, state_d;
  logic          mode_q, mode_d;
  logic [LW:0]   rem_q, rem_d;
  logic [BW-1:0] cur_q, cur_d;
  logic          pull_d1_q;
  logic          push_q, push_d;
  logic          last_q, last_d;
  logic [BW-1:0] dout_q, dout_d;
  logic [BW-1:0] sum_q, sum_d;

  logic          start_acc;
  logic          push_edge;
  logic          final_word;

  function automatic logic [BW-1:0] next_word(input logic mode, input logic [BW-1:0] cur);
    if (mode)
      next_word = {cur[BW-2:0], cur[BW-1] ^ cur[21] ^ cur[1] ^ cur[0]};
    else
      next_word = cur + {{(BW-1){1'b0}}, 1'b1};
  endfunction

  // An all-zero LFSR state would lock up, so a zero seed is replaced by 1.
  function automatic logic [BW-1:0] first_word(input logic mode, input logic [BW-1:0] seed);
    if (mode && (seed == '0))
      first_word = {{(BW-1){1'b0}}, 1'b1};
    else
      first_word = seed;
  endfunction

  assign start_acc  = (state_q == S_IDLE) && START;
  assign push_edge  = (state_q == S_RUN) && pull_d1_q && !ABORT;
  assign final_word = push_edge && (rem_q == REM_ONE);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= S_IDLE;
      mode_q    <= 1'b0;
      rem_q     <= '0;
      cur_q     <= '0;
      pull_d1_q <= 1'b0;
      push_q    <= 1'b0;
      last_q    <= 1'b0;
      dout_q    <= '0;
      sum_q     <= '0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      rem_q     <= rem_d;
      cur_q     <= cur_d;
      pull_d1_q <= DOPULL;
      push_q    <= push_d;
      last_q    <= last_d;
      dout_q    <= dout_d;
      sum_q     <= sum_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (START) state_d = S_RUN;
      S_RUN:  if (ABORT || final_word) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output-register next values; a non-push edge drops the strobes and holds the data.
  always_comb begin
    mode_d = mode_q;
    rem_d  = rem_q;
    cur_d  = cur_q;
    push_d = 1'b0;
    last_d = 1'b0;
    dout_d = dout_q;
    sum_d  = sum_q;
    if (start_acc) begin
      mode_d = MODE;
      rem_d  = {1'b0, LEN} + REM_ONE;
      cur_d  = first_word(MODE, SEED);
      sum_d  = '0;
    end else if (push_edge) begin
      push_d = 1'b1;
      last_d = final_word;
      dout_d = cur_q;
      sum_d  = sum_q ^ cur_q;
      cur_d  = next_word(mode_q, cur_q);
      rem_d  = rem_q - REM_ONE;
    end
  end

  assign BUSY   = (state_q == S_RUN);
  assign DOPUSH = push_q;
  assign DOUT   = dout_q;
  assign DOLAST = last_q;
  assign SUM    = sum_q;

endmodule

// File: doc/pp_burst_tx.md
PP_BURST_TX -- requirements
Module: pp_burst_tx

Interface
REQ-001 Parameters, one per line:
  BW  32  data word width; LFSR taps fixed at bits BW-1, 21, 1, 0; BW >= 24
  LW  8   burst-length field width; burst = LEN+1 words (1..2^LW)
REQ-002 Ports, one per line:
  CLK     in   1      single clock, all logic on rising edge
  RST     in   1      reset, asynchronous, active-high
  START   in   1      start burst (accepted in IDLE only)
  ABORT   in   1      terminate burst (honoured in RUN only)
  MODE    in   1      0 = increment pattern, 1 = LFSR pattern
  LEN     in   LW     burst length minus one
  SEED    in   BW     first data word
  BUSY    out  1      burst in progress
  DOPULL  in   1      sink may accept words (level, from downstream DIPULL)
  DOPUSH  out  1      DOUT valid this cycle, one word per high cycle
  DOUT    out  BW     data word
  DOLAST  out  1      final word of a non-aborted burst, qualifies DOPUSH
  SUM     out  BW     running XOR of words pushed in current/last burst
REQ-003 One clock; reset is asynchronous and active-high; ports named CLK and RST.
REQ-004 All outputs driven directly from flops, no combinational path from any input.

Function
REQ-005 FSM has two states, IDLE and RUN; BUSY = (state == RUN).
REQ-006 IDLE -> RUN at an edge where START = 1; at that edge capture MODE, remaining = LEN+1, cur = SEED (LFSR mode with SEED = 0 substitutes 1), SUM cleared to 0.
REQ-007 START in RUN is ignored; ABORT in IDLE is ignored; START and ABORT together in IDLE: START wins.
REQ-008 pull_d1 is a register sampling DOPULL every edge.
REQ-009 Push edge: state RUN, pull_d1 = 1, ABORT = 0; then DOPUSH <= 1, DOUT <= cur, SUM <= SUM ^ cur, cur <= next(cur), remaining <= remaining - 1.
REQ-010 Non-push edge: DOPUSH <= 0, DOLAST <= 0; DOUT, SUM, and cur hold.
REQ-011 Flow-control bound: DOPUSH high in cycle c only if DOPULL was high in cycle c-2; after DOPULL falls, at most 2 further words are pushed.
REQ-012 First word: earliest DOPUSH is 2 cycles after the START cycle, given DOPULL held high.
REQ-013 Increment mode: next = cur + 1 mod 2^BW; all-ones wraps to 0.
REQ-014 LFSR mode: next = {cur[BW-2:0], cur[BW-1]^cur[21]^cur[1]^cur[0]}.
REQ-015 Last word (push edge with remaining = 1): DOLAST <= 1 with DOPUSH; state -> IDLE at the same edge.
REQ-016 BUSY is low in the cycle carrying the last word; START in that cycle is accepted, giving a minimum 1-cycle DOPUSH gap between bursts.
REQ-017 ABORT in RUN: state -> IDLE, no push at that edge, DOLAST never asserted for that burst; SUM holds the XOR of words already pushed.
REQ-018 remaining is LW+1 bits wide; LEN = 2^LW-1 yields 2^LW words.

Reset
REQ-019 RST = 1 asynchronously forces state IDLE and clears DOPUSH, DOLAST, BUSY, DOUT, SUM, cur, remaining, and pull_d1 to 0.
REQ-020 Reset mid-burst abandons the burst; no DOPUSH in the cycle after RST deasserts; the next START starts a fresh burst.

Verification
REQ-021 Benches shall cover:
  - Increment mode, LEN=3, SEED=0x10, DOPULL=1: DOUT 0x10, 0x11, 0x12, 0x13 on consecutive cycles; DOLAST on 0x13; SUM=0x00.
  - Increment mode, SEED=0xFFFFFFFE, LEN=2: DOUT 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000.
  - LFSR mode, SEED=0, LEN=1: DOUT 0x00000001, then 0x00000003.
  - DOPULL toggled randomly during LEN=255 burst: 256 words in order; no DOPUSH more than 2 cycles after DOPULL low; no DOPUSH unless DOPULL high 2 cycles earlier.
  - ABORT after 5 words of LEN=9: no further DOPUSH, DOLAST stays 0, BUSY low next cycle; SUM = XOR of the 5 words.
  - RST pulsed mid-burst, then START LEN=0 SEED=0xA5: exactly one word 0xA5 with DOLAST.
